// File: rtl/core_pkg.sv
// Shared definitions for the data-memory responder:
// funct3 encodings, FSM states and configuration checks.
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam int MIN_LATENCY = 1;
    localparam int MIN_DEPTH   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int depth, input int latency);
        return is_pow2(depth) && (depth >= MIN_DEPTH)
            && (latency >= MIN_LATENCY);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// RV64 byte-lane alignment: load extraction/extension,
// store lane mask and data shift, misalign/illegal detection.
module lsu_align
    import core_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] rword_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] ldata_o,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [5:0]  shamt;
    logic [63:0] rsh;
    logic [7:0]  bmask;

    always_comb begin
        shamt      = {offset_i, 3'b000};
        rsh        = rword_i >> shamt;
        bmask      = 8'h00;
        misalign_o = 1'b0;
        // funct3[1:0] encodes the access size for loads and stores
        unique case ({1'b0, funct3_i[1:0]})
            F3_SB: bmask = 8'h01;
            F3_SH: begin
                bmask      = 8'h03;
                misalign_o = offset_i[0];
            end
            F3_SW: begin
                bmask      = 8'h0f;
                misalign_o = |offset_i[1:0];
            end
            F3_SD: begin
                bmask      = 8'hff;
                misalign_o = |offset_i;
            end
            default: bmask = 8'h00;
        endcase
        wmask_o   = bmask << offset_i;
        wdata_o   = wdata_i << shamt;
        illegal_o = store_i ? (funct3_i > F3_SD)
                            : (funct3_i == 3'b111);
        unique case (funct3_i)
            F3_LB:   ldata_o = {{56{rsh[7]}}, rsh[7:0]};
            F3_LH:   ldata_o = {{48{rsh[15]}}, rsh[15:0]};
            F3_LW:   ldata_o = {{32{rsh[31]}}, rsh[31:0]};
            F3_LD:   ldata_o = rsh;
            F3_LBU:  ldata_o = {56'd0, rsh[7:0]};
            F3_LHU:  ldata_o = {48'd0, rsh[15:0]};
            F3_LWU:  ldata_o = {32'd0, rsh[31:0]};
            default: ldata_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding
// load/store served from a 64-bit-wide internal RAM.
module dmem_responder
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [63:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit CFG_OK = cfg_ok(DEPTH_WORDS, LATENCY);

    if (!CFG_OK) begin : g_cfg_check
        $error("dmem_responder: bad DEPTH_WORDS/LATENCY");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              store_q, store_d;
    logic [63:0]       addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic          idle_fast;
    logic          a_store;
    logic [63:0]   a_addr;
    logic [2:0]    a_f3;
    logic [63:0]   a_wdata;
    logic [AW-1:0] widx;
    logic          range_err;
    logic [63:0]   ldata;
    logic [7:0]    wmask;
    logic [63:0]   wdata_sh;
    logic          misalign;
    logic          illegal;
    logic          acc_err;
    logic [63:0]   acc_rdata;
    logic          do_access;
    logic          we;

    // With LATENCY=1 the access happens on the accept edge itself
    assign idle_fast = (state_q == ST_IDLE) && (LATENCY == 1);

    always_comb begin
        a_store   = idle_fast ? req_store_i  : store_q;
        a_addr    = idle_fast ? req_addr_i   : addr_q;
        a_f3      = idle_fast ? req_funct3_i : f3_q;
        a_wdata   = idle_fast ? req_wdata_i  : wdata_q;
        widx      = a_addr[3 +: AW];
        range_err = |a_addr[63:3+AW];
    end

    lsu_align u_align (
        .store_i    (a_store),
        .funct3_i   (a_f3),
        .offset_i   (a_addr[2:0]),
        .rword_i    (mem[widx]),
        .wdata_i    (a_wdata),
        .ldata_o    (ldata),
        .wmask_o    (wmask),
        .wdata_o    (wdata_sh),
        .misalign_o (misalign),
        .illegal_o  (illegal)
    );

    always_comb begin
        acc_err   = range_err | misalign | illegal;
        acc_rdata = (acc_err || a_store) ? 64'd0 : ldata;
        do_access = ((state_q == ST_WAIT) && (cnt_q == '0))
                  || (idle_fast && req_valid_i);
        we        = do_access && a_store && !acc_err && !reset;
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (we && wmask[b]) begin
                mem[widx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        store_d      = store_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    store_d = req_store_i;
                    addr_d  = req_addr_i;
                    f3_d    = req_funct3_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        rdata_d      = acc_rdata;
                        err_d        = acc_err;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = acc_rdata;
                    err_d        = acc_err;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            store_q      <= 1'b0;
            addr_q       <= 64'd0;
            f3_q         <= 3'd0;
            wdata_q      <= 64'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 64'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            store_q      <= store_d;
            addr_q       <= addr_d;
            f3_q         <= f3_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, 4096 words)
// with hand-computed expected responses.
module tb_dmem_responder;
    import core_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_store_i = 1'b0;
    logic [63:0] req_addr_i = 64'd0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [63:0] req_wdata_i = 64'd0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH_WORDS (4096),
        .LATENCY     (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_store_i  (req_store_i),
        .req_addr_i   (req_addr_i),
        .req_funct3_i (req_funct3_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] f3,
                         input logic [63:0] a,
                         input logic [63:0] wd);
        req_valid_i  = 1'b1;
        req_store_i  = st;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = wd;
    endtask

    // Edges after the accept edge until resp_valid; capped at 20.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!resp_valid_o && lat < 20);
    endtask

    task automatic xfer(input string tag, input logic st,
                        input logic [2:0] f3,
                        input logic [63:0] a,
                        input logic [63:0] wd,
                        input logic [63:0] exp_rd,
                        input logic exp_er);
        int lat;
        chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        drive(st, f3, a, wd);
        tick();
        req_valid_i = 1'b0;
        wait_valid(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_rdata"}, resp_rdata_o, exp_rd);
        chk({tag, "_err"}, 64'(resp_err_o), 64'(exp_er));
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        chk({tag, "_drop"}, 64'(resp_valid_o), 64'd0);
    endtask

    initial begin
        int lat;
        #12;
        chk("rst_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_rdata", resp_rdata_o, 64'd0);
        chk("rst_err", 64'(resp_err_o), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'd1);

        xfer("sd10", 1, F3_SD, 64'h10, 64'h1122334455667788,
             64'd0, 0);
        xfer("ld10", 0, F3_LD, 64'h10, 64'd0,
             64'h1122334455667788, 0);
        xfer("sb13", 1, F3_SB, 64'h13, 64'hFF, 64'd0, 0);
        xfer("lb13", 0, F3_LB, 64'h13, 64'd0,
             64'hFFFFFFFFFFFFFFFF, 0);
        xfer("lbu13", 0, F3_LBU, 64'h13, 64'd0, 64'hFF, 0);
        xfer("ld10b", 0, F3_LD, 64'h10, 64'd0,
             64'h11223344FF667788, 0);
        xfer("lhu16", 0, F3_LHU, 64'h16, 64'd0, 64'h1122, 0);
        xfer("lw10", 0, F3_LW, 64'h10, 64'd0,
             64'hFFFFFFFFFF667788, 0);
        xfer("lwu10", 0, F3_LWU, 64'h10, 64'd0,
             64'h00000000FF667788, 0);
        xfer("lh14", 0, F3_LH, 64'h14, 64'd0, 64'h3344, 0);
        xfer("lw14", 0, F3_LW, 64'h14, 64'd0, 64'h11223344, 0);

        xfer("lw12", 0, F3_LW, 64'h12, 64'd0, 64'd0, 1);
        xfer("sw16", 1, F3_SW, 64'h16, 64'hDEADBEEF, 64'd0, 1);
        xfer("ld10c", 0, F3_LD, 64'h10, 64'd0,
             64'h11223344FF667788, 0);
        xfer("ld_oor", 0, F3_LD, 64'h8000, 64'd0, 64'd0, 1);
        xfer("ld_f7", 0, 3'b111, 64'h10, 64'd0, 64'd0, 1);
        xfer("st_f4", 1, 3'b100, 64'h10, 64'h0, 64'd0, 1);
        xfer("ld10d", 0, F3_LD, 64'h10, 64'd0,
             64'h11223344FF667788, 0);
        xfer("sd_top", 1, F3_SD, 64'h7FF8, 64'hCAFEF00D12345678,
             64'd0, 0);
        xfer("ld_top", 0, F3_LD, 64'h7FF8, 64'd0,
             64'hCAFEF00D12345678, 0);

        // Backpressure with a competing store held on the request side
        drive(0, F3_LD, 64'h10, 64'd0);
        tick();
        drive(1, F3_SD, 64'h10, 64'd0);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_rdata", resp_rdata_o, 64'h11223344FF667788);
            chk("bp_err", 64'(resp_err_o), 64'd0);
            chk("bp_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        chk("bp_drop", 64'(resp_valid_o), 64'd0);
        chk("bp_idle", 64'(req_ready_o), 64'd1);
        xfer("ld10e", 0, F3_LD, 64'h10, 64'd0,
             64'h11223344FF667788, 0);

        // Reset while a store waits: it must never be written
        xfer("sd20", 1, F3_SD, 64'h20, 64'h5555555555555555,
             64'd0, 0);
        drive(1, F3_SD, 64'h20, 64'hAA);
        tick();
        req_valid_i = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rstw_valid", 64'(resp_valid_o), 64'd0);
        chk("rstw_ready", 64'(req_ready_o), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        xfer("ld20", 0, F3_LD, 64'h20, 64'd0,
             64'h5555555555555555, 0);

        // Reset while a response is pending: valid falls at once
        drive(0, F3_LD, 64'h10, 64'd0);
        tick();
        req_valid_i = 1'b0;
        wait_valid(lat);
        chk("rstr_pre", 64'(resp_valid_o), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstr_valid", 64'(resp_valid_o), 64'd0);
        chk("rstr_rdata", resp_rdata_o, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        xfer("ld10f", 0, F3_LD, 64'h10, 64'd0,
             64'h11223344FF667788, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
